// File: rtl/table_writer.sv
// -----------------------------------------------------------------------------
// table_writer
//
// Run-time loader for the Aho-Corasick goto/failure tables. A byte stream
// carries a one-byte header N (entry count, 1..DEPTH) followed by N records
// of four bytes each: current_state, chara, next_state, failure_state.
// Complete records are written into four parallel arrays, which are read
// back through a registered read port by the table reader.
//
// Handshake: a byte moves on a rising CLK edge where IN_VALID and IN_READY
// are both high. IN_READY is a registered decode of the FSM state (high in
// HEADER and LOAD only) and never looks at IN_VALID; the producer may hold
// IN_VALID low for any number of cycles and parsing simply waits.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   START               one-cycle pulse that begins or restarts a load
//   IN_VALID/IN_DATA    load-stream byte and its qualifier
//   IN_READY            writer accepts a byte this cycle
//   RD_ADDR             read address; RD_* follow one cycle later
//   RD_CURRENT/RD_CHARA/RD_NEXT/RD_FAILURE  registered table fields
//   ENTRY_COUNT         entry count of the last successful load
//   BUSY                load in progress (HEADER or LOAD)
//   DONE                one-cycle pulse on successful completion
//   ERROR               sticky malformed-load flag, cleared by START
//   TABLE_VALID         table contents complete and consistent
//   DBG_STATE           current FSM state, for observation only
// -----------------------------------------------------------------------------
module table_writer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int SW    = 8,
    parameter int CW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          IN_VALID,
    input  logic [7:0]    IN_DATA,
    output logic          IN_READY,
    input  logic [AW-1:0] RD_ADDR,
    output logic [SW-1:0] RD_CURRENT,
    output logic [CW-1:0] RD_CHARA,
    output logic [SW-1:0] RD_NEXT,
    output logic [SW-1:0] RD_FAILURE,
    output logic [AW:0]   ENTRY_COUNT,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERROR,
    output logic          TABLE_VALID,
    output logic [2:0]    DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_LOAD   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [8:0] MAX_N = 9'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t        state, state_n;
    logic [1:0]    field_q;       // byte position inside the current record
    logic [AW:0]   wr_ptr;        // records written so far; one extra bit so N==DEPTH does not alias
    logic [AW:0]   n_q;           // entry count latched from the header
    logic [SW-1:0] cur_s;
    logic [CW-1:0] chr_s;
    logic [SW-1:0] nxt_s;

    logic xfer;
    logic hdr_ok;
    logic chara_bad;
    logic last_rec;
    logic latch_n;
    logic stage_en;
    logic wr_en;

    logic [SW-1:0] mem_cur  [DEPTH];
    logic [CW-1:0] mem_chr  [DEPTH];
    logic [SW-1:0] mem_nxt  [DEPTH];
    logic [SW-1:0] mem_fail [DEPTH];

    assign xfer      = IN_VALID && IN_READY;
    assign hdr_ok    = (IN_DATA != 8'd0) && ({1'b0, IN_DATA} <= MAX_N);
    assign chara_bad = (IN_DATA[7:4] != 4'd0);
    assign last_rec  = ((wr_ptr + ONE) == n_q);
    assign DBG_STATE = state;

    // Next state and per-cycle strobes. START overrides everything, including
    // a transfer that would complete a record or the whole load.
    always_comb begin
        state_n  = state;
        latch_n  = 1'b0;
        stage_en = 1'b0;
        wr_en    = 1'b0;
        if (START) begin
            state_n = S_HEADER;
        end else begin
            case (state)
                S_IDLE: state_n = S_IDLE;
                S_HEADER: begin
                    if (xfer) begin
                        if (hdr_ok) begin
                            state_n = S_LOAD;
                            latch_n = 1'b1;
                        end else begin
                            state_n = S_ERR;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        if ((field_q == 2'd1) && chara_bad) begin
                            state_n = S_ERR;
                        end else if (field_q == 2'd3) begin
                            wr_en = 1'b1;
                            if (last_rec) begin
                                state_n = S_DONE;
                            end
                        end else begin
                            stage_en = 1'b1;
                        end
                    end
                end
                S_DONE:  state_n = S_IDLE;
                S_ERR:   state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State, status flags and parser registers. Status outputs are decoded
    // from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            IN_READY    <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERROR       <= 1'b0;
            TABLE_VALID <= 1'b0;
            ENTRY_COUNT <= '0;
            field_q     <= 2'd0;
            wr_ptr      <= '0;
            n_q         <= '0;
            cur_s       <= '0;
            chr_s       <= '0;
            nxt_s       <= '0;
        end else begin
            state    <= state_n;
            IN_READY <= (state_n == S_HEADER) || (state_n == S_LOAD);
            BUSY     <= (state_n == S_HEADER) || (state_n == S_LOAD);
            DONE     <= (state_n == S_DONE);

            if (START) begin
                ERROR       <= 1'b0;
                TABLE_VALID <= 1'b0;
            end else if (state_n == S_ERR) begin
                ERROR <= 1'b1;
            end else if (state_n == S_DONE) begin
                TABLE_VALID <= 1'b1;
                ENTRY_COUNT <= n_q;
            end

            if (START) begin
                // Abort: anything staged for a partial record is dropped.
                field_q <= 2'd0;
                wr_ptr  <= '0;
                cur_s   <= '0;
                chr_s   <= '0;
                nxt_s   <= '0;
            end else if (latch_n) begin
                n_q     <= IN_DATA[AW:0];
                field_q <= 2'd0;
                wr_ptr  <= '0;
            end else if (stage_en) begin
                field_q <= field_q + 2'd1;
                case (field_q)
                    2'd0:    cur_s <= SW'(IN_DATA);
                    2'd1:    chr_s <= IN_DATA[CW-1:0];
                    default: nxt_s <= SW'(IN_DATA);
                endcase
            end else if (wr_en) begin
                field_q <= 2'd0;
                wr_ptr  <= wr_ptr + ONE;
            end
        end
    end

    // Table arrays: all four fields of a record land together when the
    // failure byte arrives. Contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_cur[wr_ptr[AW-1:0]]  <= cur_s;
            mem_chr[wr_ptr[AW-1:0]]  <= chr_s;
            mem_nxt[wr_ptr[AW-1:0]]  <= nxt_s;
            mem_fail[wr_ptr[AW-1:0]] <= SW'(IN_DATA);
        end
    end

    // Registered read port, free-running in every state. A same-address
    // write in the same cycle returns the previous contents.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RD_CURRENT <= '0;
            RD_CHARA   <= '0;
            RD_NEXT    <= '0;
            RD_FAILURE <= '0;
        end else begin
            RD_CURRENT <= mem_cur[RD_ADDR];
            RD_CHARA   <= mem_chr[RD_ADDR];
            RD_NEXT    <= mem_nxt[RD_ADDR];
            RD_FAILURE <= mem_fail[RD_ADDR];
        end
    end

endmodule
